// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and constants for the multi-channel PWM block.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module      : pwm_timebase
// Description : Shared prescaled timebase (sawtooth or triangle) with period
//               boundary detection and a one-clock period_start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  center_mode_i,
    output logic [WIDTH-1:0]      cnt_o,
    output logic                  boundary_o,
    output logic                  period_start_o,
    output logic                  running_o
);

    localparam logic [WIDTH-1:0] c_cnt_max = '1;

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    pwm_mode_t             mode_q, mode_d;
    logic                  run_q, run_d;
    logic                  pstart_q, pstart_d;
    logic                  w_tick;
    logic                  w_boundary;

    // A live prescale lowered below presc_q must still produce a tick.
    assign w_tick = enable_i && run_q && (presc_q >= prescale_i);

    always_comb begin
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        run_d      = enable_i;
        w_boundary = 1'b0;

        if (!enable_i) begin
            presc_d = '0;
            cnt_d   = '0;
            dir_d   = DIR_UP;
        end else if (!run_q) begin
            // First enabled clock: start a fresh period with cnt held at 0.
            w_boundary = 1'b1;
            presc_d    = '0;
            cnt_d      = '0;
            dir_d      = DIR_UP;
        end else begin
            presc_d = w_tick ? '0 : presc_q + 1'b1;
            if (w_tick) begin
                if (mode_q == PWM_EDGE) begin
                    cnt_d = cnt_q + 1'b1;
                    dir_d = DIR_UP;
                    if (cnt_q == c_cnt_max) begin
                        w_boundary = 1'b1;
                    end
                end else if (dir_q == DIR_UP) begin
                    if (cnt_q == c_cnt_max) begin
                        cnt_d = c_cnt_max - 1'b1;
                        dir_d = DIR_DOWN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
                        w_boundary = 1'b1;
                        dir_d      = DIR_UP;
                    end
                end
            end
        end

        // The counting rule of the ending period decides the wrap; the new
        // mode governs only from the boundary onward.
        if (w_boundary) begin
            mode_d = pwm_mode_t'(center_mode_i);
        end
        pstart_d = w_boundary;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            dir_q    <= DIR_UP;
            mode_q   <= PWM_EDGE;
            run_q    <= 1'b0;
            pstart_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            run_q    <= run_d;
            pstart_q <= pstart_d;
        end
    end

    assign cnt_o          = cnt_q;
    assign boundary_o     = w_boundary;
    assign period_start_o = pstart_q;
    assign running_o      = run_q;

endmodule : pwm_timebase
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi
// Description : Multi-channel PWM generator with shared timebase and
//               per-channel shadowed duty registers.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [PRESCALE_W-1:0]     prescale,
    input  logic                      center_mode,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic [CHANNELS-1:0]       duty_load,
    output logic [CHANNELS-1:0]       pwm_o,
    output logic                      period_start
);

    logic [WIDTH-1:0] w_cnt;
    logic             w_boundary;
    logic             w_running;

    pwm_timebase #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) u_timebase (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable),
        .prescale_i     (prescale),
        .center_mode_i  (center_mode),
        .cnt_o          (w_cnt),
        .boundary_o     (w_boundary),
        .period_start_o (period_start),
        .running_o      (w_running)
    );

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] pend_q;
        logic [WIDTH-1:0] act_q;
        logic             pwm_q;

        // Active duty takes the pending value as it stood before this edge,
        // so a load coinciding with a boundary waits for the next one.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pend_q <= '0;
                act_q  <= '0;
                pwm_q  <= 1'b0;
            end else begin
                if (duty_load[k]) begin
                    pend_q <= duty[k*WIDTH +: WIDTH];
                end
                if (w_boundary) begin
                    act_q <= pend_q;
                end
                pwm_q <= enable && w_running && (w_cnt < act_q);
            end
        end

        assign pwm_o[k] = pwm_q;
    end

endmodule : pwm_multi
`default_nettype wire

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, parametrised PWM generator that supersedes the single-channel 8-bit free-running PWM. All channels share one timebase, which has a programmable clock prescaler and either edge-aligned (sawtooth) or center-aligned (triangle) counting. Each channel has its own shadowed duty register, so duty updates are glitch-free and take effect only at a period boundary. The block sits between the register/IO logic and the output pads and drives LED, motor and audio-style loads.

## Interface
- `WIDTH`, 8: counter and duty resolution in bits.
- `CHANNELS`, 4: number of independent PWM outputs.
- `PRESCALE_W`, 8: prescaler setting width.

- `clk`  in  1  system clock; everything is on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `enable`  in  1  run control; low stops and clears the timebase.
- `prescale`  in  PRESCALE_W  timebase advances once every `prescale+1` clocks.
- `center_mode`  in  1  0 = edge-aligned, 1 = center-aligned; shadowed.
- `duty`  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `duty_load`  in  CHANNELS  per-channel strobe; captures that channel's `duty` slice into its pending register.
- `pwm_o`  out  CHANNELS  registered PWM outputs.
- `period_start`  out  1  one-clock pulse at the start of each period.

## Operation
- **Prescaler**
  - `presc_cnt` counts 0..`prescale`.
  - `tick` is asserted when `presc_cnt == prescale`; `presc_cnt` returns to 0 on that clock.
  - `prescale = 0` gives a tick every clock.
  - `prescale` is sampled live. If it is lowered below the current `presc_cnt`, that clock is treated as a tick.
- **Edge mode**
  - `cnt` increments on each tick and wraps from 2^WIDTH-1 to 0.
  - Period is 2^WIDTH ticks.
- **Center mode**
  - `cnt` counts up 0..2^WIDTH-1, then down to 0, with direction held in `dir`.
  - The maximum and 0 each appear once per period, so the period is 2*(2^WIDTH-1) ticks.
- **Boundary**
  - A boundary is the tick on which `cnt` becomes 0 at the start of a new period, or the first clock after `enable` rises.
  - At a boundary, each channel's active duty is loaded from its pending register, and the active mode is loaded from `center_mode`.
- **Shadow loading**
  - `duty_load[k]` always writes the pending register only.
  - A load on the same clock as a boundary takes effect at the next boundary, not the current one.
- **Compare**
  - pwm_o[k] <= enable & (cnt < active_duty[k]), unsigned.
  - Duty 0 gives a constant low output.
  - Duty 2^WIDTH-1 gives high for all but one counter value per up-ramp. 100% duty is not supported.
- **Enable low**
  - `presc_cnt`, `cnt` and `dir` clear to 0/up.
  - `pwm_o` is 0 from the next clock.
  - Pending registers still accept loads.
- **Reset** (`rst_n` low at a clock edge, including mid-period)
  - `presc_cnt`, `cnt`, `dir`, all active and pending duties, and the active mode clear to 0.
  - `pwm_o` = 0 and `period_start` = 0.

## Timing
- `pwm_o` reflects the `cnt` value of the previous clock, i.e. one clock of latency.
- The active duty and `cnt`=0 update on the same edge, so the first compared value of a new period already uses the new duty.
- `period_start` is high for exactly one clock: the first clock in which `cnt` holds 0 of a new period. With `prescale > 0`, `cnt` holds 0 for several clocks but the pulse is still one clock.
- Edge-mode period = 2^WIDTH*(prescale+1) clocks.
- Center-mode period = 2*(2^WIDTH-1)*(prescale+1) clocks.

## Structure
- Package `pwm_pkg`:
  - `pwm_mode_t` enum (`PWM_EDGE` = 0, `PWM_CENTER` = 1).
  - Direction constants `DIR_UP` and `DIR_DOWN`.
- Sub-module `pwm_timebase`:
  - contains the prescaler, `cnt`, `dir`, active mode, boundary detection and `period_start`;
  - exports `cnt`, `boundary` and `period_start`.
- The top level holds a generate loop over channels containing the pending/active registers and the compare flop.

## Test plan
All scenarios use WIDTH=8 and CHANNELS=4.
- **Reset:** toggle inputs with `rst_n`=0, then release with `enable`=0 → `pwm_o`=0 and `period_start`=0 throughout; pending duties read back as 0 (outputs stay low after enable until a load).
- **Edge mode, basic duties:** `prescale`=0; load ch0=64, ch1=0, ch2=255, ch3=128; raise `enable` → per 256 clocks, ch0 is high for 64, ch1 for 0, ch2 for 255, ch3 for 128; `period_start` every 256 clocks.
- **Prescaler:** `prescale`=3, ch0=128 → `pwm_o[0]` high for 512 of every 1024 clocks; `period_start` pulses one clock wide every 1024 clocks.
- **Shadow update:** ch0 running at 200; load 32 mid-period, and separately load on the exact boundary clock → the current period still shows 200 high; the new value appears at the first and second following period respectively.
- **Center mode:** `prescale`=0, ch0=100 → period 510 clocks with 199 high clocks (100 on the up-ramp, 99 on the down-ramp); a mode switch mid-period takes effect at the next boundary only.
- **Mid-operation disable and reset:** drop `enable` mid-period → `pwm_o` is 0 the next clock; re-enable → `period_start` fires and `cnt` restarts at 0. Assert `rst_n` mid-period → all state clears on that edge.
